// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-beat host command to APB requester with PREADY timeout
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_WIDTH   = 5
) (
    input  logic                  PCLK_i,
    input  logic                  PRESET_i,
    input  logic                  CMD_VALID_i,
    output logic                  CMD_READY_o,
    input  logic                  CMD_WRITE_i,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR_i,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA_i,
    output logic                  RSP_VALID_o,
    output logic [DATA_WIDTH-1:0] RSP_RDATA_o,
    output logic                  RSP_ERR_o,
    output logic                  PSEL_o,
    output logic                  PENABLE_o,
    output logic [ADDR_WIDTH-1:0] PADDR_o,
    output logic                  PWRITE_o,
    output logic [DATA_WIDTH-1:0] PWDATA_o,
    input  logic [DATA_WIDTH-1:0] PRDATA_i,
    input  logic                  PREADY_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit                      TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [TO_CNT_WIDTH-1:0] to_cnt, to_cnt_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;
    logic                    rsp_valid_nxt, rsp_err_nxt;
    logic                    accept, timed_out;

    assign CMD_READY_o = (state == IDLE) && !PRESET_i;
    assign accept      = CMD_VALID_i && CMD_READY_o;
    assign timed_out   = TO_EN && (to_cnt == TO_LAST);

    // State and all registered outputs; reset also aborts any transfer in flight.
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state       <= IDLE;
            to_cnt      <= '0;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            PADDR_o     <= '0;
            PWRITE_o    <= 1'b0;
            PWDATA_o    <= '0;
            RSP_VALID_o <= 1'b0;
            RSP_RDATA_o <= '0;
            RSP_ERR_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            to_cnt      <= to_cnt_nxt;
            PSEL_o      <= psel_nxt;
            PENABLE_o   <= penable_nxt;
            PADDR_o     <= paddr_nxt;
            PWRITE_o    <= pwrite_nxt;
            PWDATA_o    <= pwdata_nxt;
            RSP_VALID_o <= rsp_valid_nxt;
            RSP_RDATA_o <= rsp_rdata_nxt;
            RSP_ERR_o   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY_i || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        to_cnt_nxt    = to_cnt;
        psel_nxt      = PSEL_o;
        penable_nxt   = PENABLE_o;
        paddr_nxt     = PADDR_o;
        pwrite_nxt    = PWRITE_o;
        pwdata_nxt    = PWDATA_o;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = RSP_RDATA_o;
        rsp_err_nxt   = RSP_ERR_o;
        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (accept) begin
                    psel_nxt   = 1'b1;
                    paddr_nxt  = CMD_ADDR_i;
                    pwrite_nxt = CMD_WRITE_i;
                    pwdata_nxt = CMD_WRITE_i ? CMD_WDATA_i : '0;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                to_cnt_nxt  = '0;
            end
            ACCESS: begin
                if (PREADY_i) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = PWRITE_o ? '0 : PRDATA_i;
                end else if (timed_out) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

    logic       clk = 1'b0;
    logic       preset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite, pready;
    logic [7:0] paddr, pwdata, prdata;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_pulses = 0;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] prdata;
        logic       stale;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_access;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    vec_t vecs[7];
    rsp_t sb[$];
    rsp_t exp_rsp;

    apb_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .TO_CNT_WIDTH(5)
    ) dut (
        .PCLK_i(clk), .PRESET_i(preset),
        .CMD_VALID_i(cmd_valid), .CMD_READY_o(cmd_ready), .CMD_WRITE_i(cmd_write),
        .CMD_ADDR_i(cmd_addr), .CMD_WDATA_i(cmd_wdata),
        .RSP_VALID_o(rsp_valid), .RSP_RDATA_o(rsp_rdata), .RSP_ERR_o(rsp_err),
        .PSEL_o(psel), .PENABLE_o(penable), .PADDR_o(paddr), .PWRITE_o(pwrite),
        .PWDATA_o(pwdata), .PRDATA_i(prdata), .PREADY_i(pready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_pulses++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_rsp = sb.pop_front();
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rsp.rdata});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_rsp.err});
            end
        end
    end

    // Entered at a negedge; returns at the negedge of the response cycle.
    task automatic do_cmd(input vec_t v);
        int  wait_cyc;
        int  acc;
        bit  done;
        logic [7:0] exp_pwdata;
        exp_pwdata = v.write ? v.wdata : 8'h00;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        if (v.stale) pready = 1'b1;
        wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("accept_wait", wait_cyc, 0);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("setup_psel", {31'd0, psel}, 1);
        chk("setup_penable", {31'd0, penable}, 0);
        chk("setup_paddr", {24'd0, paddr}, {24'd0, v.addr});
        chk("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
        chk("setup_pwdata", {24'd0, pwdata}, {24'd0, exp_pwdata});
        acc  = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (psel && penable) begin
                acc++;
                if (!v.stale) pready = (acc > v.waits);
                prdata = v.prdata;
                chk("access_paddr", {24'd0, paddr}, {24'd0, v.addr});
                chk("access_pwdata", {24'd0, pwdata}, {24'd0, exp_pwdata});
            end else begin
                done = 1;
            end
        end
        chk("access_cycles", acc, v.exp_access);
        chk("rsp_psel_low", {31'd0, psel | penable}, 0);
        chk("rsp_cmd_ready", {31'd0, cmd_ready}, 1);
        if (!v.stale) pready = 1'b0;
    endtask

    int pulses_before;

    initial begin
        //         write addr   wdata  waits prdata stale exp_rd exp_err exp_acc
        vecs[0] = '{1'b1, 8'h03, 8'hA5, 0,   8'h5A, 1'b0, 8'h00, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h05, 8'hFF, 3,   8'h3C, 1'b0, 8'h3C, 1'b0, 4};
        vecs[2] = '{1'b0, 8'h07, 8'h00, 255, 8'h99, 1'b0, 8'h00, 1'b1, 16};
        vecs[3] = '{1'b1, 8'h01, 8'h11, 0,   8'hEE, 1'b1, 8'h00, 1'b0, 1};
        vecs[4] = '{1'b1, 8'h02, 8'h22, 0,   8'hEE, 1'b1, 8'h00, 1'b0, 1};
        vecs[5] = '{1'b0, 8'h0A, 8'h00, 15,  8'h77, 1'b0, 8'h77, 1'b0, 16};
        vecs[6] = '{1'b1, 8'h1F, 8'h6B, 2,   8'h00, 1'b0, 8'h00, 1'b0, 3};

        preset    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 8'hAA;
        pready    = 1'b0;
        prdata    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("reset_bus", {27'd0, psel, penable, pwrite, |paddr, |pwdata}, 0);
        chk("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 0);
        preset    = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        chk("post_reset_idle", {31'd0, psel | penable}, 0);

        for (int i = 0; i < 7; i++) begin
            do_cmd(vecs[i]);
            if (i == 4) pready = 1'b0;
        end

        // Reset in the middle of an ACCESS wait state.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h09;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_setup", {30'd0, psel, penable}, 2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_access", {30'd0, psel, penable}, 3);
        pulses_before = rsp_pulses;
        preset = 1'b1;
        @(negedge clk);
        chk("mid_reset_bus", {29'd0, psel, penable, rsp_valid}, 0);
        chk("mid_reset_ready", {31'd0, cmd_ready}, 0);
        preset = 1'b0;
        @(negedge clk);
        chk("mid_reset_no_rsp", rsp_pulses, pulses_before);
        do_cmd('{1'b0, 8'h04, 8'h00, 1, 8'hC3, 1'b0, 8'hC3, 1'b0, 2});

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("rsp_pulse_total", rsp_pulses, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
